dport_sram: RTL and testbench
=============================

Name: dport_sram

Overview:
Single-port synchronous data SRAM target that sits directly downstream of the merlin32i data port (dreq*/drsp*). It accepts one load/store request per cycle under ready/valid handshake, derives byte enables from size and address, and returns exactly one in-order response per request. A small response queue absorbs core-side backpressure, so full throughput holds while drspready is high.

Parameters:
C_DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
C_BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*C_DEPTH_WORDS.
C_RSP_DEPTH, 2, response queue entries; at least 2.

Ports:
clk_i  in  1  clock, rising edge
resetb_i  in  1  asynchronous active-low reset
clk_en_i  in  1  clock enable; when low, no state changes
treqready_o  out  1  request accepted this cycle if treqvalid_i is also high
treqvalid_i  in  1  request valid
treqdvalid_i  in  1  1 = store, 0 = load
treqsize_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
treqaddr_i  in  32  byte address
treqdata_i  in  32  store data, lane-aligned (byte at lane addr[1:0])
trspready_i  in  1  core accepts response
trspvalid_o  out  1  response valid
trsprerr_o  out  1  load error
trspwerr_o  out  1  store error
trspdata_o  out  32  full aligned word for loads; 0 for stores and errors

Behaviour:
- Reset (async assert, sync release): treqready_o=0 while resetb_i=0, then 1; trspvalid_o=0, trsprerr_o=0, trspwerr_o=0, trspdata_o=0. Queue and in-flight state are flushed. RAM contents are not reset and are retained across reset.
- Accept: treqvalid_i & treqready_o & clk_en_i at a rising edge.
- treqready_o = (queued + in-flight) < C_RSP_DEPTH. This is registered-count based, with no combinational path from trspready_i.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Range: an address is in range iff (addr - C_BASE_ADDR) < 4*C_DEPTH_WORDS. Word index = (addr - C_BASE_ADDR)[log2(C_DEPTH_WORDS)+1:2].
- Store, no error: enabled bytes are written at the accept edge. The response is werr=0, data=0.
- Load, no error: the RAM is read at the accept edge (synchronous read). Data is pushed to the queue one edge later.
- Error (out of range, or misaligned when enabled): no RAM write. The response has rerr (load) or werr (store) set and data=0.
- Latency: with the queue empty, trspvalid_o is high in the cycle after the accept edge.
- Back-to-back requests give 1 response per cycle while trspready_i=1.
- Read-after-write: a load accepted the edge after a store to the same word returns the written data.
- Response pop: trspvalid_o & trspready_i & clk_en_i. Outputs are driven from the queue head. Simultaneous push and pop at full occupancy is legal and the count is unchanged.
- Full: treqready_o=0. The request is held by the core, and the data path is untouched.
- Empty: trspvalid_o=0, trspdata_o=0, err=0.
- clk_en_i=0: no accept, no pop, no RAM access, no count change. Outputs hold.
- Reset mid-operation: in-flight responses are discarded. A store accepted at an edge before reset assertion remains written.

Optional Feature:
DPORT_SRAM_MISALIGN_ERR_EN
- Defined: a half with addr[0]=1 or a word with addr[1:0]!=0 flags rerr/werr and performs no write.
- Undefined: addr[1:0] is ignored for half and word (forced aligned, half to addr[1]). No misalign errors occur; only range errors remain.

Decomposition:
- Package dport_sram_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - function byte_en(size, addr_lsb) returning 4 bits
  - function misaligned(size, addr_lsb)
  - response struct {rerr, werr, data[31:0]}
- One sub-module, dport_sram_rspq: a synchronous FIFO of depth C_RSP_DEPTH with count output. It supports simultaneous push/pop, and its push is the registered accept-stage result.

Test Plan:
- Store word 32'hDEAD_BEEF @0x10, then load word @0x10 on the next cycle, trspready_i=1 -> store rsp werr=0, data=0; load rsp data=32'hDEAD_BEEF; responses valid in consecutive cycles.
- Store byte 32'h0000_5A00 @0x11, then load word @0x10 -> data=32'hDEAD_5AEF.
- Eight back-to-back loads with trspready_i=0 -> treqready_o drops after 2 accepts. Release trspready_i -> all 8 responses arrive in order, with no loss or duplicate.
- Load @C_BASE_ADDR+4*C_DEPTH_WORDS -> rerr=1, data=0. Store there -> werr=1, and RAM is unchanged (re-read word 0 and last word).
- Store half @0x13:
  - macro defined -> werr=1, no write.
  - macro undefined -> bytes 0x12..0x13 are written.
- Assert resetb_i with 2 responses queued -> trspvalid_o=0 immediately. After release, treqready_o=1, and a load @0x10 returns the pre-reset data.

Source files
------------

// File: rtl/dport_sram_pkg.sv
// dport_sram_pkg: shared types and helpers for the dport_sram data SRAM.
// Size encodings, byte-enable and misalignment helpers, response record.
// Build option: DPORT_SRAM_MISALIGN_ERR_EN turns misaligned half/word into errors.
package dport_sram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

`ifdef DPORT_SRAM_MISALIGN_ERR_EN
    localparam bit MISALIGN_ERR_EN = 1'b1;
`else
    localparam bit MISALIGN_ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rerr;
        logic        werr;
        logic [31:0] data;
    } rsp_t;

    // Half and word are always forced to their natural alignment here;
    // when misalignment is an error, the write is suppressed upstream.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] addr_lsb);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lsb;
            SZ_HALF: be = 4'b0011 << {addr_lsb[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Encoding 3 is reserved and behaves as a word.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lsb);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lsb[0];
            default: mis = (addr_lsb != 2'b00);
        endcase
        return MISALIGN_ERR_EN & mis;
    endfunction

endpackage

// File: rtl/dport_sram_rspq.sv
// dport_sram_rspq: small synchronous response FIFO with occupancy count.
// Ports: clk_i, resetb_i, clk_en_i, push_i/push_data_i, pop_i, head_o, count_o.
module dport_sram_rspq
    import dport_sram_pkg::*;
#(
    parameter int unsigned C_DEPTH = 2,
    localparam int CW = $clog2(C_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          resetb_i,
    input  logic          clk_en_i,
    input  logic          push_i,
    input  rsp_t          push_data_i,
    input  logic          pop_i,
    output rsp_t          head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(C_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(C_DEPTH - 1);

    rsp_t          slots [C_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = clk_en_i & pop_i & (count != '0);
    // A pop in the same cycle frees a slot, so push at full is allowed then.
    assign do_push = clk_en_i & push_i & ((count != FULL) | do_pop);

    assign head_o  = slots[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/dport_sram.sv
// dport_sram: single-port synchronous data SRAM behind the merlin32i data port.
// Ports: clk_i, resetb_i, clk_en_i; treq* request handshake; trsp* responses.
// Build option: DPORT_SRAM_MISALIGN_ERR_EN (see dport_sram_pkg).
module dport_sram
    import dport_sram_pkg::*;
#(
    parameter int unsigned C_DEPTH_WORDS = 1024,
    parameter logic [31:0] C_BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned C_RSP_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [1:0]  treqsize_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic        trsprerr_o,
    output logic        trspwerr_o,
    output logic [31:0] trspdata_o
);

    localparam int AW = $clog2(C_DEPTH_WORDS);
    localparam int CW = $clog2(C_RSP_DEPTH + 1);
    localparam logic [32:0] SPAN = 33'(C_DEPTH_WORDS) << 2;
    localparam logic [CW-1:0] LIMIT = CW'(C_RSP_DEPTH);

    logic [31:0]   mem [C_DEPTH_WORDS];
    logic [31:0]   ram_q;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic          req_err;
    logic          accept;

    // Accept-stage result, one per accepted request.
    logic          s1_valid;
    logic          s1_load_ok;
    logic          s1_rerr;
    logic          s1_werr;
    rsp_t          s1_rsp;

    rsp_t          q_head;
    rsp_t          rsp_head;
    logic [CW-1:0] q_count;
    logic [CW-1:0] occupancy;
    logic          q_empty;
    logic          pop;
    logic          push;

    assign offset   = treqaddr_i - C_BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign widx     = offset[AW+1:2];
    assign be       = byte_en(treqsize_i, treqaddr_i[1:0]);
    assign req_err  = ~in_range | misaligned(treqsize_i, treqaddr_i[1:0]);

    // Occupancy counts the accept-stage slot so the queue can never overflow.
    assign occupancy   = q_count + CW'(s1_valid);
    assign treqready_o = resetb_i & (occupancy < LIMIT);
    assign accept      = treqvalid_i & treqready_o & clk_en_i;

    always_ff @(posedge clk_i) begin
        if (accept && !req_err) begin
            if (treqdvalid_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[widx][8*b +: 8] <= treqdata_i[8*b +: 8];
                    end
                end
            end else begin
                ram_q <= mem[widx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s1_valid   <= 1'b0;
            s1_load_ok <= 1'b0;
            s1_rerr    <= 1'b0;
            s1_werr    <= 1'b0;
        end else if (clk_en_i) begin
            s1_valid   <= accept;
            s1_load_ok <= accept & ~treqdvalid_i & ~req_err;
            s1_rerr    <= accept & ~treqdvalid_i & req_err;
            s1_werr    <= accept & treqdvalid_i & req_err;
        end
    end

    assign s1_rsp = '{rerr: s1_rerr,
                      werr: s1_werr,
                      data: s1_load_ok ? ram_q : 32'h0};

    // With the queue empty the accept-stage result is presented directly,
    // giving one-cycle latency; popped there, it never enters the queue.
    assign q_empty     = (q_count == '0);
    assign rsp_head    = q_empty ? s1_rsp : q_head;
    assign trspvalid_o = ~q_empty | s1_valid;
    assign pop         = trspvalid_o & trspready_i & clk_en_i;
    assign push        = s1_valid & ~(q_empty & pop);

    assign trsprerr_o  = rsp_head.rerr;
    assign trspwerr_o  = rsp_head.werr;
    assign trspdata_o  = rsp_head.data;

    dport_sram_rspq #(
        .C_DEPTH(C_RSP_DEPTH)
    ) u_rspq (
        .clk_i      (clk_i),
        .resetb_i   (resetb_i),
        .clk_en_i   (clk_en_i),
        .push_i     (push),
        .push_data_i(s1_rsp),
        .pop_i      (pop & ~q_empty),
        .head_o     (q_head),
        .count_o    (q_count)
    );

endmodule

// File: tb/tb_dport_sram.sv
// tb_dport_sram: table vectors, hand sequences and random traffic for dport_sram.
// Responses are scored against a byte-addressed memory model and expected queue.
module tb_dport_sram;

    localparam int DEPTH = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef DPORT_SRAM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        resetb_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic        treqvalid_i = 1'b0;
    logic        treqdvalid_i = 1'b0;
    logic [1:0]  treqsize_i = 2'd0;
    logic [31:0] treqaddr_i = 32'h0;
    logic [31:0] treqdata_i = 32'h0;
    logic        trspready_i = 1'b1;
    logic        treqready_o;
    logic        trspvalid_o;
    logic        trsprerr_o;
    logic        trspwerr_o;
    logic [31:0] trspdata_o;

    always #5 clk_i = ~clk_i;

    dport_sram #(
        .C_DEPTH_WORDS(DEPTH),
        .C_BASE_ADDR  (BASE),
        .C_RSP_DEPTH  (2)
    ) dut (
        .clk_i       (clk_i),
        .resetb_i    (resetb_i),
        .clk_en_i    (clk_en_i),
        .treqready_o (treqready_o),
        .treqvalid_i (treqvalid_i),
        .treqdvalid_i(treqdvalid_i),
        .treqsize_i  (treqsize_i),
        .treqaddr_i  (treqaddr_i),
        .treqdata_i  (treqdata_i),
        .trspready_i (trspready_i),
        .trspvalid_o (trspvalid_o),
        .trsprerr_o  (trsprerr_o),
        .trspwerr_o  (trspwerr_o),
        .trspdata_o  (trspdata_o)
    );

    typedef struct packed {
        logic        rerr;
        logic        werr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          dv;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        rerr;
        logic        werr;
        logic [31:0] q;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] mmem [4*DEPTH];
    int         checks = 0;
    int         errors = 0;
    int         n_pop = 0;
    bit         rand_mode = 1'b0;
    vec_t       tab [20];

    task automatic chk(input string name, input logic [33:0] act,
                       input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int wb;
        wb = int'(a - BASE) & ~3;
        return {mmem[wb+3], mmem[wb+2], mmem[wb+1], mmem[wb]};
    endfunction

    // Reference: range check on the offset, then lane-wise byte access.
    task automatic model_req(input bit dv, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d,
                             output exp_t r);
        logic [31:0] off;
        int lo, n, wb;
        bit ok;
        off = a - BASE;
        lo = int'(a[1:0]);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ok = (off < 4 * DEPTH);
        if (MIS && (lo % n != 0)) ok = 1'b0;
        lo = lo - (lo % n);
        wb = int'(off) & ~3;
        r = '0;
        if (dv) begin
            r.werr = !ok;
            if (ok) begin
                for (int i = 0; i < n; i++) begin
                    mmem[wb + lo + i] = d[8*(lo+i) +: 8];
                end
            end
        end else begin
            r.rerr = !ok;
            if (ok) r.data = word_at(off + BASE);
        end
    endtask

    // Scoreboard: score the presented response, then model any new accept.
    always @(negedge clk_i) begin
        exp_t e;
        exp_t r;
        if (resetb_i && clk_en_i) begin
            if (trspvalid_o && trspready_i) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %h, expected none",
                             trspdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_order", {trsprerr_o, trspwerr_o, trspdata_o}, e);
                end
            end
            if (treqvalid_i && treqready_o) begin
                model_req(treqdvalid_i, treqsize_i, treqaddr_i, treqdata_i, r);
                exp_q.push_back(r);
            end
        end
    end

    always @(posedge clk_i) begin
        if (rand_mode) begin
            #1;
            clk_en_i = ($urandom_range(0, 4) != 0);
            trspready_i = ($urandom_range(0, 2) != 0);
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input bit dv, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        treqvalid_i = 1'b1;
        treqdvalid_i = dv;
        treqsize_i = sz;
        treqaddr_i = a;
        treqdata_i = d;
        while (!acc && t < 200) begin
            @(negedge clk_i);
            acc = treqready_o && clk_en_i;
            t++;
            if (!acc) begin
                @(posedge clk_i);
                #1;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept at %h", a);
        end
        @(posedge clk_i);
        #1;
        treqvalid_i = 1'b0;
    endtask

    task automatic xfer(input vec_t v, input string name);
        send(v.dv, v.sz, v.a, v.d);
        @(negedge clk_i);
        chk({name, "_valid"}, 34'(trspvalid_o), 34'(1));
        chk({name, "_rsp"}, {trsprerr_o, trspwerr_o, trspdata_o},
            {v.rerr, v.werr, v.q});
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk_i);
            t++;
        end
        chk(name, 34'(exp_q.size()), 34'(0));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base_pop;
        tab[0]  = '{1, 2'd2, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0};
        tab[1]  = '{0, 2'd2, 32'h10, 32'h0, 0, 0, 32'hDEAD_BEEF};
        tab[2]  = '{1, 2'd0, 32'h11, 32'h0000_5A00, 0, 0, 32'h0};
        tab[3]  = '{0, 2'd2, 32'h10, 32'h0, 0, 0, 32'hDEAD_5AEF};
        tab[4]  = '{1, 2'd2, 32'h0, 32'h0BAD_F00D, 0, 0, 32'h0};
        tab[5]  = '{1, 2'd2, 32'hFFC, 32'hCAFE_0001, 0, 0, 32'h0};
        tab[6]  = '{0, 2'd2, 32'h1000, 32'h0, 1, 0, 32'h0};
        tab[7]  = '{1, 2'd2, 32'h1000, 32'hFFFF_FFFF, 0, 1, 32'h0};
        tab[8]  = '{0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0BAD_F00D};
        tab[9]  = '{0, 2'd2, 32'hFFC, 32'h0, 0, 0, 32'hCAFE_0001};
        tab[10] = '{1, 2'd1, 32'h13, 32'h7E81_0000, 0, MIS, 32'h0};
        tab[11] = '{0, 2'd2, 32'h10, 32'h0, 0, 0,
                    MIS ? 32'hDEAD_5AEF : 32'h7E81_5AEF};
        tab[12] = '{0, 2'd0, 32'h11, 32'h0, 0, 0,
                    MIS ? 32'hDEAD_5AEF : 32'h7E81_5AEF};
        tab[13] = '{1, 2'd3, 32'h20, 32'h1122_3344, 0, 0, 32'h0};
        tab[14] = '{0, 2'd3, 32'h20, 32'h0, 0, 0, 32'h1122_3344};
        tab[15] = '{0, 2'd2, 32'hFFFF_FFFC, 32'h0, 1, 0, 32'h0};
        tab[16] = '{1, 2'd1, 32'h22, 32'hBEEF_0000, 0, 0, 32'h0};
        tab[17] = '{0, 2'd2, 32'h20, 32'h0, 0, 0, 32'hBEEF_3344};
        tab[18] = '{1, 2'd2, 32'h21, 32'hAAAA_BBBB, 0, MIS, 32'h0};
        tab[19] = '{0, 2'd2, 32'h20, 32'h0, 0, 0,
                    MIS ? 32'hBEEF_3344 : 32'hAAAA_BBBB};

        #2;
        chk("rst_ready", 34'(treqready_o), 34'(0));
        chk("rst_valid", 34'(trspvalid_o), 34'(0));
        chk("rst_rsp", {trsprerr_o, trspwerr_o, trspdata_o}, 34'(0));
        repeat (2) @(posedge clk_i);
        #1;
        resetb_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", 34'(treqready_o), 34'(1));
        @(posedge clk_i);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            send(1'b1, 2'd2, BASE + 32'(4 * i), $urandom);
        end
        drain("fill_drain");

        // Store then load on consecutive cycles; responses back to back.
        treqvalid_i = 1'b1;
        treqdvalid_i = 1'b1;
        treqsize_i = 2'd2;
        treqaddr_i = 32'h10;
        treqdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("raw_st_ready", 34'(treqready_o), 34'(1));
        @(posedge clk_i);
        #1;
        treqdvalid_i = 1'b0;
        treqdata_i = 32'h0;
        @(negedge clk_i);
        chk("raw_ld_ready", 34'(treqready_o), 34'(1));
        chk("raw_st_valid", 34'(trspvalid_o), 34'(1));
        chk("raw_st_rsp", {trsprerr_o, trspwerr_o, trspdata_o}, 34'(0));
        @(posedge clk_i);
        #1;
        treqvalid_i = 1'b0;
        @(negedge clk_i);
        chk("raw_ld_valid", 34'(trspvalid_o), 34'(1));
        chk("raw_ld_rsp", {trsprerr_o, trspwerr_o, trspdata_o},
            {2'b00, 32'hDEAD_BEEF});
        @(posedge clk_i);
        #1;
        drain("raw_drain");

        for (int i = 0; i < 20; i++) begin
            xfer(tab[i], $sformatf("vec%0d", i));
        end
        drain("tab_drain");

        // Backpressure: two accepts fill the queue, then the rest follow.
        base_pop = n_pop;
        trspready_i = 1'b0;
        treqvalid_i = 1'b1;
        treqdvalid_i = 1'b0;
        treqsize_i = 2'd2;
        treqaddr_i = 32'h100;
        @(negedge clk_i);
        chk("bp_ready0", 34'(treqready_o), 34'(1));
        @(posedge clk_i);
        #1;
        treqaddr_i = 32'h104;
        @(negedge clk_i);
        chk("bp_ready1", 34'(treqready_o), 34'(1));
        @(posedge clk_i);
        #1;
        treqaddr_i = 32'h108;
        repeat (3) begin
            @(negedge clk_i);
            chk("bp_stall", 34'(treqready_o), 34'(0));
            chk("bp_head_valid", 34'(trspvalid_o), 34'(1));
            chk("bp_head", 34'(trspdata_o), 34'(word_at(32'h100)));
            @(posedge clk_i);
            #1;
        end
        trspready_i = 1'b1;
        for (int i = 2; i < 8; i++) begin
            send(1'b0, 2'd2, 32'h100 + 32'(4 * i), 32'h0);
        end
        drain("bp_drain");
        chk("bp_count", 34'(n_pop - base_pop), 34'(8));

        // Random traffic with clock-enable and ready throttling.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = BASE + 32'($urandom_range(0, 4 * DEPTH + 63));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 a, $urandom);
        end
        rand_mode = 1'b0;
        @(posedge clk_i);
        #1;
        clk_en_i = 1'b1;
        trspready_i = 1'b1;
        drain("rand_drain");

        // Reset with two responses outstanding.
        trspready_i = 1'b0;
        send(1'b1, 2'd2, 32'h10, 32'h1234_5678);
        send(1'b0, 2'd2, 32'h10, 32'h0);
        #2;
        resetb_i = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 34'(trspvalid_o), 34'(0));
        chk("mid_rst_ready", 34'(treqready_o), 34'(0));
        chk("mid_rst_rsp", {trsprerr_o, trspwerr_o, trspdata_o}, 34'(0));
        @(posedge clk_i);
        #1;
        resetb_i = 1'b1;
        trspready_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", 34'(treqready_o), 34'(1));
        chk("post_rst_valid", 34'(trspvalid_o), 34'(0));
        @(posedge clk_i);
        #1;
        xfer('{0, 2'd2, 32'h10, 32'h0, 0, 0, 32'h1234_5678}, "post_rst_ld");
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
